// File: rtl/vliw_ctrl_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vliw_ctrl_seq_if                                                     |
// | Fetch-side handshake and datapath control bundle of vliw_ctrl_seq.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface vliw_ctrl_seq_if #(
  parameter int IR_W = 32
);
  logic            ir_valid;
  logic [IR_W-1:0] ir;
  logic            ir_ready;
  logic            n_flag;
  logic            mem_ready;
  logic            ctrl_valid;
  logic            reg_write1;
  logic            reg_write2;
  logic [3:0]      flag1_we;
  logic [3:0]      flag2_we;
  logic [1:0]      alu_op;
  logic            alu_src_a;
  logic            alu_src_b;
  logic            branch;
  logic [1:0]      pc_src;
  logic            mem_read;
  logic            mem_write;
  logic            illegal;
  logic            mem_err;

  // Fetch register / datapath side
  modport master (
    output ir_valid, ir, n_flag, mem_ready,
    input  ir_ready, ctrl_valid, reg_write1, reg_write2, flag1_we, flag2_we,
           alu_op, alu_src_a, alu_src_b, branch, pc_src, mem_read, mem_write,
           illegal, mem_err
  );

  // Sequencer side
  modport slave (
    input  ir_valid, ir, n_flag, mem_ready,
    output ir_ready, ctrl_valid, reg_write1, reg_write2, flag1_we, flag2_we,
           alu_op, alu_src_a, alu_src_b, branch, pc_src, mem_read, mem_write,
           illegal, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/vliw_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vliw_ctrl_seq                                                        |
// | Registered two-slot VLIW control sequencer: decode, memory wait with |
// | timeout, branch flush window. Optional: VLIW_CTRL_ILLEGAL_TRAP_EN.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vliw_ctrl_seq #(
  parameter int IR_W         = 32,
  parameter int OPW          = 5,
  parameter int OP1_LSB      = 0,
  parameter int SUB1_LSB     = 5,
  parameter int OP2_LSB      = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  wire            clk,
  input  wire            reset,
  vliw_ctrl_seq_if.slave bus
);

`ifdef VLIW_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_CYCLES);
  localparam logic [FCNT_W-1:0] FLUSH_ONE  = FCNT_W'(1);
  localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  localparam logic [OPW-1:0] OP1_NOP    = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP1_ALU    = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP1_IMM    = OPW'(5'b00101);
  localparam logic [OPW-1:0] SUB1_04    = OPW'(5'b00100);
  localparam logic [OPW-1:0] SUB1_0B    = OPW'(5'b01011);
  localparam logic [OPW-1:0] SUB1_0C    = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP2_NOP    = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP2_LOAD   = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP2_STORE  = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP2_JUMP   = OPW'(5'b11110);
  localparam logic [OPW-1:0] OP2_BRANCH = OPW'(5'b11011);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_TRAP     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              ir_ready_q, ir_ready_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic              reg_write1_q, reg_write1_d;
  logic              reg_write2_q, reg_write2_d;
  logic [3:0]        flag1_we_q, flag1_we_d;
  logic [3:0]        flag2_we_q, flag2_we_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              alu_src_a_q, alu_src_a_d;
  logic              alu_src_b_q, alu_src_b_d;
  logic              branch_q, branch_d;
  logic [1:0]        pc_src_q, pc_src_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              illegal_q, illegal_d;
  logic              mem_err_q, mem_err_d;

  logic [OPW-1:0] op1, sub1, op2;
  logic           accept;
  logic           s1_rw, s1_a, s1_b, s1_ill;
  logic [3:0]     s1_flags;
  logic [1:0]     s1_alu;
  logic           s2_ld, s2_st, s2_br, s2_ill;
  logic [1:0]     s2_pc;
  logic           unused_ir;

  assign op1       = bus.ir[OP1_LSB +: OPW];
  assign sub1      = bus.ir[SUB1_LSB +: OPW];
  assign op2       = bus.ir[OP2_LSB +: OPW];
  assign accept    = bus.ir_valid && ir_ready_q;
  assign unused_ir = ^bus.ir;

  always_comb begin
    s1_rw    = 1'b0;
    s1_a     = 1'b0;
    s1_b     = 1'b0;
    s1_ill   = 1'b0;
    s1_flags = 4'b0000;
    s1_alu   = 2'b00;
    case (op1)
      OP1_ALU: begin
        s1_rw = 1'b1;
        s1_a  = 1'b1;
        case (sub1)
          SUB1_04: begin s1_alu = 2'b00; s1_flags = 4'b1111; end
          SUB1_0B: begin s1_alu = 2'b11; s1_flags = 4'b1110; end
          SUB1_0C: begin s1_alu = 2'b10; s1_flags = 4'b1100; end
          default: begin s1_ill = 1'b1; s1_rw = 1'b0; s1_a = 1'b0; end
        endcase
      end
      OP1_IMM: begin
        s1_rw    = 1'b1;
        s1_b     = 1'b1;
        s1_alu   = 2'b01;
        s1_flags = 4'b1111;
      end
      OP1_NOP: ;
      default: s1_ill = 1'b1;
    endcase
  end

  always_comb begin
    s2_ld  = 1'b0;
    s2_st  = 1'b0;
    s2_br  = 1'b0;
    s2_ill = 1'b0;
    s2_pc  = 2'b00;
    case (op2)
      OP2_LOAD:   s2_ld = 1'b1;
      OP2_STORE:  s2_st = 1'b1;
      OP2_JUMP:   s2_pc = 2'b10;
      OP2_BRANCH: begin
        s2_br = 1'b1;
        s2_pc = bus.n_flag ? 2'b01 : 2'b00;
      end
      OP2_NOP: ;
      default: s2_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    wcnt_d       = wcnt_q;
    ir_ready_d   = ir_ready_q;
    ctrl_valid_d = 1'b0;
    reg_write1_d = 1'b0;
    reg_write2_d = 1'b0;
    flag1_we_d   = 4'b0000;
    flag2_we_d   = 4'b0000;
    alu_op_d     = 2'b00;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 1'b0;
    branch_d     = 1'b0;
    pc_src_d     = 2'b00;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    illegal_d    = 1'b0;
    mem_err_d    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          ctrl_valid_d = 1'b1;
          illegal_d    = s1_ill || s2_ill;
          if (TRAP_EN && (s1_ill || s2_ill)) begin
            pc_src_d   = 2'b11;
            ir_ready_d = 1'b0;
            state_d    = ST_TRAP;
          end else begin
            reg_write1_d = s1_rw;
            flag1_we_d   = s1_flags;
            alu_op_d     = s1_alu;
            alu_src_a_d  = s1_a;
            alu_src_b_d  = s1_b;
            branch_d     = s2_br;
            pc_src_d     = s2_pc;
            mem_read_d   = s2_ld;
            mem_write_d  = s2_st;
            // A memory op takes priority over flushing in a combined word
            if (s2_ld || s2_st) begin
              ir_ready_d = 1'b0;
              wcnt_d     = '0;
              state_d    = ST_MEM_WAIT;
            end else if ((s2_pc != 2'b00) && (FLUSH_CYCLES > 0)) begin
              fcnt_d  = FLUSH_INIT;
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_MEM_WAIT: begin
        // mem_ready is checked first so a late ack on the last cycle still wins
        if (bus.mem_ready) begin
          if (mem_read_q) begin
            reg_write2_d = 1'b1;
            flag2_we_d   = 4'b1100;
          end
          wcnt_d     = '0;
          ir_ready_d = 1'b1;
          state_d    = ST_RUN;
        end else if ((MEM_TIMEOUT > 0) && (wcnt_q == WAIT_LAST)) begin
          mem_err_d  = 1'b1;
          wcnt_d     = '0;
          ir_ready_d = 1'b1;
          state_d    = ST_RUN;
        end else begin
          mem_read_d  = mem_read_q;
          mem_write_d = mem_write_q;
          wcnt_d      = wcnt_q + WCNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (accept) begin
          if (fcnt_q <= FLUSH_ONE) begin
            fcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end
        end
      end
      ST_TRAP: ir_ready_d = 1'b0;
      default: begin
        ir_ready_d = 1'b1;
        state_d    = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      fcnt_q       <= '0;
      wcnt_q       <= '0;
      ir_ready_q   <= 1'b1;
      ctrl_valid_q <= 1'b0;
      reg_write1_q <= 1'b0;
      reg_write2_q <= 1'b0;
      flag1_we_q   <= 4'b0000;
      flag2_we_q   <= 4'b0000;
      alu_op_q     <= 2'b00;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 1'b0;
      branch_q     <= 1'b0;
      pc_src_q     <= 2'b00;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      wcnt_q       <= wcnt_d;
      ir_ready_q   <= ir_ready_d;
      ctrl_valid_q <= ctrl_valid_d;
      reg_write1_q <= reg_write1_d;
      reg_write2_q <= reg_write2_d;
      flag1_we_q   <= flag1_we_d;
      flag2_we_q   <= flag2_we_d;
      alu_op_q     <= alu_op_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      branch_q     <= branch_d;
      pc_src_q     <= pc_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      illegal_q    <= illegal_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign bus.ir_ready   = ir_ready_q;
  assign bus.ctrl_valid = ctrl_valid_q;
  assign bus.reg_write1 = reg_write1_q;
  assign bus.reg_write2 = reg_write2_q;
  assign bus.flag1_we   = flag1_we_q;
  assign bus.flag2_we   = flag2_we_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_src_a  = alu_src_a_q;
  assign bus.alu_src_b  = alu_src_b_q;
  assign bus.branch     = branch_q;
  assign bus.pc_src     = pc_src_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.illegal    = illegal_q;
  assign bus.mem_err    = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vliw_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vliw_ctrl_seq                                                     |
// | Directed bench for vliw_ctrl_seq with an expected-bundle scoreboard. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vliw_ctrl_seq;

  typedef struct packed {
    logic       cv;
    logic       rw1;
    logic       rw2;
    logic [3:0] f1;
    logic [3:0] f2;
    logic [1:0] alu;
    logic       sa;
    logic       sb;
    logic       br;
    logic [1:0] pc;
    logic       mr;
    logic       mw;
    logic       ill;
    logic       err;
    logic       rdy;
  } bundle_t;

  logic    clk = 1'b0;
  logic    reset;
  bundle_t obs;
  bundle_t e;
  bundle_t sb_q[$];
  int      n_assert = 0;
  int      n_fail = 0;

  vliw_ctrl_seq_if #(.IR_W(32)) bus ();

  vliw_ctrl_seq #(
    .IR_W(32), .OPW(5), .OP1_LSB(0), .SUB1_LSB(5), .OP2_LSB(16),
    .FLUSH_CYCLES(2), .MEM_TIMEOUT(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.ctrl_valid, bus.reg_write1, bus.reg_write2, bus.flag1_we, bus.flag2_we,
                bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.branch, bus.pc_src,
                bus.mem_read, bus.mem_write, bus.illegal, bus.mem_err, bus.ir_ready};

  function automatic logic [31:0] mkw(input logic [4:0] o1, input logic [4:0] s1, input logic [4:0] o2);
    logic [31:0] w;
    w        = '0;
    w[4:0]   = o1;
    w[9:5]   = s1;
    w[20:16] = o2;
    return w;
  endfunction

  function automatic bundle_t idle_b(input logic rdy);
    bundle_t b;
    b     = '0;
    b.rdy = rdy;
    return b;
  endfunction

  function automatic bundle_t add_b();
    bundle_t b;
    b     = idle_b(1'b1);
    b.cv  = 1'b1;
    b.rw1 = 1'b1;
    b.f1  = 4'b1111;
    b.alu = 2'b00;
    b.sa  = 1'b1;
    return b;
  endfunction

  task automatic chk(input string tag);
    bundle_t x;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      x = sb_q.pop_front();
      assert (obs === x) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, x);
      end
    end
  endtask

  task automatic cyc(input bundle_t x, input string tag);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    bus.ir_valid = v;
    bus.ir       = w;
  endtask

  initial begin
    reset         = 1'b1;
    bus.ir_valid  = 1'b0;
    bus.ir        = '0;
    bus.n_flag    = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(idle_b(1'b1));
    chk("reset_state");
    reset = 1'b0;

    // Slot-1 ALU variants, then return to idle
    drive(1'b1, mkw(5'b01000, 5'b00100, 5'b00000));
    cyc(add_b(), "alu_sub04");
    drive(1'b1, mkw(5'b01000, 5'b01011, 5'b00000));
    e = add_b(); e.alu = 2'b11; e.f1 = 4'b1110;
    cyc(e, "alu_sub0b");
    drive(1'b1, mkw(5'b01000, 5'b01100, 5'b00000));
    e = add_b(); e.alu = 2'b10; e.f1 = 4'b1100;
    cyc(e, "alu_sub0c");
    drive(1'b1, mkw(5'b00101, 5'b10101, 5'b00000));
    e = idle_b(1'b1); e.cv = 1'b1; e.rw1 = 1'b1; e.sb = 1'b1; e.alu = 2'b01; e.f1 = 4'b1111;
    cyc(e, "imm_op");
    drive(1'b0, '0);
    cyc(idle_b(1'b1), "pulse_end");

    // mem_ready outside MEM_WAIT has no effect
    bus.mem_ready = 1'b1;
    cyc(idle_b(1'b1), "mr_ignored");
    bus.mem_ready = 1'b0;

    // Load with ack three cycles after accept
    drive(1'b1, mkw(5'b00000, 5'b00000, 5'b01010));
    e = idle_b(1'b0); e.cv = 1'b1; e.mr = 1'b1;
    cyc(e, "ld_issue");
    drive(1'b0, '0);
    e = idle_b(1'b0); e.mr = 1'b1;
    cyc(e, "ld_wait1");
    cyc(e, "ld_wait2");
    bus.mem_ready = 1'b1;
    e = idle_b(1'b1); e.rw2 = 1'b1; e.f2 = 4'b1100;
    cyc(e, "ld_wb");
    bus.mem_ready = 1'b0;
    cyc(idle_b(1'b1), "ld_done");

    // Store that never completes: 15 wait cycles then mem_err
    drive(1'b1, mkw(5'b00000, 5'b00000, 5'b01011));
    e = idle_b(1'b0); e.cv = 1'b1; e.mw = 1'b1;
    cyc(e, "st_issue");
    drive(1'b0, '0);
    e = idle_b(1'b0); e.mw = 1'b1;
    for (int i = 0; i < 14; i++) cyc(e, "st_wait");
    e = idle_b(1'b1); e.err = 1'b1;
    cyc(e, "st_timeout");
    cyc(idle_b(1'b1), "st_done");

    // Load acked on the would-be timeout cycle: success, not mem_err
    drive(1'b1, mkw(5'b00000, 5'b00000, 5'b01010));
    e = idle_b(1'b0); e.cv = 1'b1; e.mr = 1'b1;
    cyc(e, "ld_edge_issue");
    drive(1'b0, '0);
    e = idle_b(1'b0); e.mr = 1'b1;
    for (int i = 0; i < 14; i++) cyc(e, "ld_edge_wait");
    bus.mem_ready = 1'b1;
    e = idle_b(1'b1); e.rw2 = 1'b1; e.f2 = 4'b1100;
    cyc(e, "ld_edge_wb");
    bus.mem_ready = 1'b0;

    // Taken branch: two accepted words flushed, idle gap not counted
    bus.n_flag = 1'b1;
    drive(1'b1, mkw(5'b00000, 5'b00000, 5'b11011));
    e = idle_b(1'b1); e.cv = 1'b1; e.br = 1'b1; e.pc = 2'b01;
    cyc(e, "br_taken");
    bus.n_flag = 1'b0;
    drive(1'b1, mkw(5'b01000, 5'b00100, 5'b00000));
    cyc(idle_b(1'b1), "flush_w1");
    drive(1'b0, '0);
    cyc(idle_b(1'b1), "flush_gap");
    drive(1'b1, mkw(5'b11111, 5'b00000, 5'b00000));
    cyc(idle_b(1'b1), "flush_w2_illegal");
    drive(1'b1, mkw(5'b01000, 5'b00100, 5'b00000));
    cyc(add_b(), "post_flush");

    // Not-taken branch: no flush
    drive(1'b1, mkw(5'b00000, 5'b00000, 5'b11011));
    e = idle_b(1'b1); e.cv = 1'b1; e.br = 1'b1;
    cyc(e, "br_not_taken");
    drive(1'b1, mkw(5'b01000, 5'b00100, 5'b00000));
    cyc(add_b(), "br_nt_next");

    // Jump flushes too
    drive(1'b1, mkw(5'b00000, 5'b00000, 5'b11110));
    e = idle_b(1'b1); e.cv = 1'b1; e.pc = 2'b10;
    cyc(e, "jump");
    drive(1'b1, mkw(5'b01000, 5'b00100, 5'b00000));
    cyc(idle_b(1'b1), "jmp_flush1");
    cyc(idle_b(1'b1), "jmp_flush2");
    cyc(add_b(), "jmp_post");

    // Illegal opcodes
`ifdef VLIW_CTRL_ILLEGAL_TRAP_EN
    drive(1'b1, mkw(5'b11111, 5'b00000, 5'b00000));
    e = idle_b(1'b0); e.cv = 1'b1; e.ill = 1'b1; e.pc = 2'b11;
    cyc(e, "trap_issue");
    cyc(idle_b(1'b0), "trap_hold1");
    cyc(idle_b(1'b0), "trap_hold2");
`else
    drive(1'b1, mkw(5'b11111, 5'b00000, 5'b00000));
    e = idle_b(1'b1); e.cv = 1'b1; e.ill = 1'b1;
    cyc(e, "ill_op1");
    drive(1'b1, mkw(5'b01000, 5'b00001, 5'b00000));
    cyc(e, "ill_sub1");
    drive(1'b1, mkw(5'b01000, 5'b00100, 5'b00111));
    e = add_b(); e.ill = 1'b1;
    cyc(e, "ill_op2");
    drive(1'b1, mkw(5'b11111, 5'b00000, 5'b01011));
    e = idle_b(1'b0); e.cv = 1'b1; e.ill = 1'b1; e.mw = 1'b1;
    cyc(e, "ill_op1_store");
    drive(1'b0, '0);
`endif
    drive(1'b0, '0);

    // Reset pulse clears any trap or pending access
    reset = 1'b1;
    #1;
    sb_q.push_back(idle_b(1'b1));
    chk("reset_pulse");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset in the middle of MEM_WAIT loses the writeback
    drive(1'b1, mkw(5'b00000, 5'b00000, 5'b01010));
    e = idle_b(1'b0); e.cv = 1'b1; e.mr = 1'b1;
    cyc(e, "rst_ld_issue");
    drive(1'b0, '0);
    e = idle_b(1'b0); e.mr = 1'b1;
    cyc(e, "rst_ld_wait");
    reset = 1'b1;
    #1;
    sb_q.push_back(idle_b(1'b1));
    chk("rst_mid_wait");
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(idle_b(1'b1), "rst_no_wb1");
    bus.mem_ready = 1'b0;
    cyc(idle_b(1'b1), "rst_no_wb2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vliw_ctrl_seq.md
Name: vliw_ctrl_seq

Overview:
- Registered, parametrised successor to the two-slot combinational control decoder.
- Accepts one two-slot instruction word (slot 1 = ALU op, slot 2 = memory/branch op) per handshake, decodes it, and drives a registered control bundle to the datapath.
- Adds multi-cycle memory wait with timeout, a branch/jump flush window, and illegal-opcode detection.
- Sits between the instruction fetch register and the datapath/PC mux.

Parameters:
- IR_W, 32, instruction word width
- OPW, 5, opcode/sub-opcode field width
- OP1_LSB, 0, LSB of the slot-1 opcode field
- SUB1_LSB, 5, LSB of the slot-1 sub-opcode field
- OP2_LSB, 16, LSB of the slot-2 opcode field
- FLUSH_CYCLES, 1, number of fetched words discarded after a taken branch or jump (0 = none)
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before abort (0 = wait forever)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ir_valid  in  1  instruction word valid
- ir  in  IR_W  instruction word
- ir_ready  out  1  word accepted when ir_valid&&ir_ready
- n_flag  in  1  negative flag, sampled at accept
- mem_ready  in  1  memory access complete
- ctrl_valid  out  1  bundle issue strobe, one cycle per accepted non-flushed word
- reg_write1 / reg_write2  out  1 each  register-file write enables
- flag1_we / flag2_we  out  4 each  flag write enables, ordered {z,n,c,v}
- alu_op  out  2  ALU operation
- alu_src_a / alu_src_b  out  1 each  ALU operand selects
- branch  out  1  slot 2 is a branch
- pc_src  out  2  PC source: 00 sequential, 01 branch, 10 jump, 11 trap
- mem_read / mem_write  out  1 each  memory strobes
- illegal  out  1  undefined opcode pulse
- mem_err  out  1  memory timeout pulse

Behaviour:
- Reset: all outputs 0 except ir_ready=1; state RUN; counters 0.
- All outputs are registered. Latency from accept edge to bundle is 1 cycle.
- Slot-1 decode:
  - 01000 with sub-opcode 00100: alu_op 00, flags 1111.
  - 01000 with sub-opcode 01011: alu_op 11, flags 1110.
  - 01000 with sub-opcode 01100: alu_op 10, flags 1100.
  - Any 01000 variant: reg_write1=1, src_a=1, src_b=0.
  - 00101: reg_write1=1, src_a=0, src_b=1, alu_op 01, flags 1111.
  - 00000: all slot-1 controls 0.
  - Any other opcode or sub-opcode: illegal=1, slot-1 treated as nop.
- Slot-2 decode:
  - 01010 load: mem_read=1.
  - 01011 store: mem_write=1.
  - 11110 jump: pc_src=10.
  - 11011 branch: branch=1; pc_src=01 if sampled n_flag=1, else 00.
  - 00000: nop.
  - Any other opcode: illegal=1, slot-2 treated as nop.
- Pulsed outputs: reg_write*, flag*_we, branch, pc_src, illegal and ctrl_valid last exactly 1 cycle, then return to 0.
- FSM RUN:
  - Load or store accepted -> MEM_WAIT, ir_ready=0.
  - Taken branch or jump with FLUSH_CYCLES>0 -> FLUSH.
  - Otherwise stay in RUN.
- FSM MEM_WAIT:
  - mem_read/mem_write held high; other controls 0; wait counter increments each cycle.
  - On mem_ready=1: strobes drop next cycle. A load additionally pulses reg_write2=1 and flag2_we=1100 for 1 cycle. Return to RUN with ir_ready=1.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT without mem_ready: strobes drop, mem_err pulses 1 cycle, no writeback, return to RUN.
  - mem_ready arriving on the timeout cycle counts as success.
  - mem_ready outside MEM_WAIT is ignored.
- FSM FLUSH:
  - ir_ready=1, but accepted words are discarded: no ctrl_valid, no illegal.
  - Counter decrements per accepted word; state -> RUN after FLUSH_CYCLES words.
  - Cycles with ir_valid=0 do not count.
- Reset asserted mid-MEM_WAIT or mid-FLUSH: immediate return to reset values; pending writeback is lost.

Optional Feature:
- Macro: VLIW_CTRL_ILLEGAL_TRAP_EN
- Defined: any illegal opcode latches a sticky trap. Bundle is issued with pc_src=11 and all write, memory and branch enables 0. State -> TRAP with ir_ready=0 until reset. illegal pulses once.
- Undefined: illegal pulses and the offending slot executes as nop; no TRAP state.

Test Plan:
- Word with slot1=01000/00100, slot2=00000 accepted -> next cycle ctrl_valid=1, reg_write1=1, alu_op=00, flag1_we=1111, src_a=1; all 0 the cycle after.
- Load accepted; mem_ready asserted 3 cycles later -> ir_ready=0 and mem_read=1 throughout the wait; reg_write2=1, flag2_we=1100 for one cycle; ir_ready=1 again.
- Store accepted; mem_ready never asserted, MEM_TIMEOUT=15 -> mem_write drops and mem_err pulses after 15 wait cycles; no reg_write2; state returns to RUN.
- Branch with n_flag=1, FLUSH_CYCLES=2, three further words -> pc_src=01, branch=1; next two words produce no ctrl_valid; third word issues normally. Repeat with n_flag=0 -> pc_src=00, no flush.
- slot1=11111 -> illegal=1, slot-1 controls 0. With VLIW_CTRL_ILLEGAL_TRAP_EN: pc_src=11, ir_ready stays 0 until reset.
- Reset asserted during MEM_WAIT -> all outputs 0 immediately, ir_ready=1; no writeback after release.
